autoscale_ctrl: RTL and testbench

- Frame-based shift scheduler for the autoscale datapath.
- Tracks the peak of two unsigned power streams over each FRAME_LEN-sample frame, derives the shift that fits that peak into OUT_WIDTH-HEADROOM bits, clamps it to [MIN_SHIFT, MAX_SHIFT], and applies it on frame boundaries.
- Shift increases take effect immediately; decreases require HOLD_FRAMES consecutive frames asking for them.
- Sits upstream of the shifter, driving its shift input; shares its clk and valid stream.

---
 rtl/autoscale_ctrl.sv | 168 ++++++++++++++++
 tb/tb_autoscale_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/autoscale_ctrl.sv
// Frame-based shift scheduler: tracks the per-frame peak of two power streams and issues a clamped, hysteretic shift.
// Optional feature macro: AUTOSCALE_CTRL_OVERRIDE_EN adds a direct shift override input.
module autoscale_ctrl #(
    parameter int unsigned DIN_WIDTH   = 32,
    parameter int unsigned OUT_WIDTH   = 18,
    parameter int unsigned HEADROOM    = 1,
    parameter int unsigned MIN_SHIFT   = 4,
    parameter int unsigned MAX_SHIFT   = 14,
    parameter int unsigned FRAME_LEN   = 1024,
    parameter int unsigned HOLD_FRAMES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DIN_WIDTH-1:0] din1,
    input  logic [DIN_WIDTH-1:0] din2,
    input  logic                 din_valid,
    input  logic                 frame_sync,
`ifdef AUTOSCALE_CTRL_OVERRIDE_EN
    input  logic                 override_en,
    input  logic [5:0]           override_shift,
`endif
    output logic [5:0]           shift_val,
    output logic                 shift_update,
    output logic [DIN_WIDTH-1:0] frame_peak,
    output logic                 frame_done
);

    localparam int unsigned CNT_W    = $clog2(FRAME_LEN);
    localparam int unsigned FIT_BITS = OUT_WIDTH - HEADROOM;
    localparam int unsigned HOLD_W   = $clog2(HOLD_FRAMES + 1);
    localparam logic signed [6:0] MIN_S7 = 7'(MIN_SHIFT);
    localparam logic signed [6:0] MAX_S7 = 7'(MAX_SHIFT);

    typedef enum logic [0:0] {WAIT_SYNC, RUN} state_t;

    state_t                r_state, w_state_nxt;
    logic [DIN_WIDTH-1:0]  r_acc, w_acc_nxt, w_smax, w_amax;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic                  w_frame_end;
    logic [DIN_WIDTH-1:0]  r_frame_peak;
    logic                  r_frame_done;
    logic [5:0]            r_shift_val, w_shift_nxt;
    logic                  r_shift_update, w_upd_nxt;
    logic [HOLD_W-1:0]     r_hold_cnt, w_hold_nxt, w_hold_inc;
    logic signed [6:0]     w_raw, w_target, w_cur;

    assign shift_val    = r_shift_val;
    assign shift_update = r_shift_update;
    assign frame_peak   = r_frame_peak;
    assign frame_done   = r_frame_done;

    // Frame tracking FSM: next-state, accumulator and counter
    always_comb begin
        w_smax      = (din1 > din2) ? din1 : din2;
        w_amax      = (r_acc > w_smax) ? r_acc : w_smax;
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_frame_end = 1'b0;
        case (r_state)
            WAIT_SYNC: begin
                if (din_valid && frame_sync) begin
                    w_acc_nxt   = w_smax;
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (din_valid) begin
                    // Natural frame end wins over a coincident frame_sync
                    if (r_cnt == CNT_W'(FRAME_LEN - 1)) begin
                        w_frame_end = 1'b1;
                        w_acc_nxt   = '0;
                        w_cnt_nxt   = '0;
                    end else if (frame_sync) begin
                        w_acc_nxt = w_smax;
                        w_cnt_nxt = CNT_W'(1);
                    end else begin
                        w_acc_nxt = w_amax;
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: w_state_nxt = WAIT_SYNC;
        endcase
    end

    // Target shift from the last completed frame peak
    always_comb begin
        w_raw = '0;
        for (int i = 0; i < int'(DIN_WIDTH); i++) begin
            if (r_frame_peak[i] && (i + 1 > int'(FIT_BITS))) begin
                w_raw = 7'(i + 1 - int'(FIT_BITS));
            end
        end
        if (w_raw < MIN_S7) begin
            w_target = MIN_S7;
        end else if (w_raw > MAX_S7) begin
            w_target = MAX_S7;
        end else begin
            w_target = w_raw;
        end
    end

    // Shift update rule with decrease hysteresis
    always_comb begin
        w_cur       = $signed({1'b0, r_shift_val});
        w_hold_inc  = r_hold_cnt + HOLD_W'(1);
        w_shift_nxt = r_shift_val;
        w_hold_nxt  = r_hold_cnt;
        w_upd_nxt   = 1'b0;
`ifdef AUTOSCALE_CTRL_OVERRIDE_EN
        if (override_en) begin
            w_hold_nxt = '0;
            if (override_shift < 6'(MIN_SHIFT)) begin
                w_shift_nxt = 6'(MIN_SHIFT);
            end else if (override_shift > 6'(MAX_SHIFT)) begin
                w_shift_nxt = 6'(MAX_SHIFT);
            end else begin
                w_shift_nxt = override_shift;
            end
            w_upd_nxt = (w_shift_nxt != r_shift_val);
        end else
`endif
        if (r_frame_done) begin
            if (w_target > w_cur) begin
                w_shift_nxt = w_target[5:0];
                w_hold_nxt  = '0;
                w_upd_nxt   = 1'b1;
            end else if (w_target < w_cur) begin
                if (w_hold_inc >= HOLD_W'(HOLD_FRAMES)) begin
                    w_shift_nxt = w_target[5:0];
                    w_hold_nxt  = '0;
                    w_upd_nxt   = 1'b1;
                end else begin
                    w_hold_nxt = w_hold_inc;
                end
            end else begin
                w_hold_nxt = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= WAIT_SYNC;
            r_acc          <= '0;
            r_cnt          <= '0;
            r_frame_peak   <= '0;
            r_frame_done   <= 1'b0;
            r_shift_val    <= 6'(MAX_SHIFT);
            r_shift_update <= 1'b0;
            r_hold_cnt     <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_acc          <= w_acc_nxt;
            r_cnt          <= w_cnt_nxt;
            r_frame_done   <= w_frame_end;
            if (w_frame_end) begin
                r_frame_peak <= w_amax;
            end
            r_shift_val    <= w_shift_nxt;
            r_shift_update <= w_upd_nxt;
            r_hold_cnt     <= w_hold_nxt;
        end
    end

endmodule

// File: tb/tb_autoscale_ctrl.sv
// Directed self-checking bench for autoscale_ctrl with FRAME_LEN=8, HOLD_FRAMES=2.
module tb_autoscale_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] din1, din2;
    logic        din_valid, frame_sync;
    logic [5:0]  shift_val;
    logic        shift_update;
    logic [31:0] frame_peak;
    logic        frame_done;

    int pass_cnt = 0;
    int total_cnt = 0;

    autoscale_ctrl #(.FRAME_LEN(8), .HOLD_FRAMES(2)) dut (
        .clk(clk), .rst_n(rst_n), .din1(din1), .din2(din2),
        .din_valid(din_valid), .frame_sync(frame_sync),
        .shift_val(shift_val), .shift_update(shift_update),
        .frame_peak(frame_peak), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Drives one 8-sample frame with pk at position pos, returns observations at T+1..T+3
    task automatic frame_obs(input logic sync0, input int pos, input logic on_b, input logic [31:0] pk,
                             output logic early, output logic d1, output logic [31:0] p1,
                             output logic [5:0] s2, output logic u2, output logic u3);
        early = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (frame_done) early = 1'b1;
            din_valid  = 1'b1;
            frame_sync = sync0 && (i == 0);
            din1 = (!on_b && i == pos) ? pk : (pk >> 4);
            din2 = (on_b && i == pos) ? pk : (pk >> 5);
        end
        @(negedge clk);
        din_valid = 1'b0; frame_sync = 1'b0;
        d1 = frame_done; p1 = frame_peak;
        @(negedge clk);
        s2 = shift_val; u2 = shift_update;
        @(negedge clk);
        u3 = shift_update;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; din1 = '0; din2 = '0; din_valid = 1'b0; frame_sync = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++; if (shift_val !== 6'd14) $display("FAIL reset_shift got=%0d exp=14", shift_val); else pass_cnt++;
        total_cnt++; if (shift_update !== 1'b0) $display("FAIL reset_update got=%b exp=0", shift_update); else pass_cnt++;
        total_cnt++; if (frame_peak !== 32'h0) $display("FAIL reset_peak got=%h exp=0", frame_peak); else pass_cnt++;
        total_cnt++; if (frame_done !== 1'b0) $display("FAIL reset_done got=%b exp=0", frame_done); else pass_cnt++;
    endtask

    task automatic test_no_sync();
        logic seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            din_valid = 1'b1; frame_sync = 1'b0; din1 = 32'h8000_0000; din2 = 32'h1;
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            din_valid = 1'b0;
            if (frame_done) seen = 1'b1;
        end
        total_cnt++; if (seen !== 1'b0) $display("FAIL nosync_done got=%b exp=0", seen); else pass_cnt++;
        total_cnt++; if (shift_val !== 6'd14) $display("FAIL nosync_shift got=%0d exp=14", shift_val); else pass_cnt++;
    endtask

    task automatic test_hold_decrease();
        logic e, d1, u2, u3; logic [31:0] p1; logic [5:0] s2;
        frame_obs(1'b1, 3, 1'b1, 32'h0040_0000, e, d1, p1, s2, u2, u3);
        total_cnt++; if (d1 !== 1'b1) $display("FAIL holdA_done got=%b exp=1", d1); else pass_cnt++;
        total_cnt++; if (p1 !== 32'h0040_0000) $display("FAIL holdA_peak got=%h exp=00400000", p1); else pass_cnt++;
        total_cnt++; if (s2 !== 6'd14) $display("FAIL holdA_shift got=%0d exp=14", s2); else pass_cnt++;
        total_cnt++; if (u2 !== 1'b0) $display("FAIL holdA_update got=%b exp=0", u2); else pass_cnt++;
        frame_obs(1'b0, 6, 1'b1, 32'h0040_0000, e, d1, p1, s2, u2, u3);
        total_cnt++; if (s2 !== 6'd6) $display("FAIL holdB_shift got=%0d exp=6", s2); else pass_cnt++;
        total_cnt++; if (u2 !== 1'b1) $display("FAIL holdB_update got=%b exp=1", u2); else pass_cnt++;
        total_cnt++; if (u3 !== 1'b0) $display("FAIL holdB_pulse_len got=%b exp=0", u3); else pass_cnt++;
    endtask

    task automatic test_increase_clamp();
        logic e, d1, u2, u3; logic [31:0] p1; logic [5:0] s2;
        frame_obs(1'b0, 0, 1'b0, 32'h8000_0000, e, d1, p1, s2, u2, u3);
        total_cnt++; if (p1 !== 32'h8000_0000) $display("FAIL inc_peak got=%h exp=80000000", p1); else pass_cnt++;
        total_cnt++; if (s2 !== 6'd14) $display("FAIL inc_shift got=%0d exp=14", s2); else pass_cnt++;
        total_cnt++; if (u2 !== 1'b1) $display("FAIL inc_update got=%b exp=1", u2); else pass_cnt++;
    endtask

    task automatic test_min_clamp();
        logic e, d1, u2, u3; logic [31:0] p1; logic [5:0] s2;
        frame_obs(1'b0, 7, 1'b0, 32'h0001_0000, e, d1, p1, s2, u2, u3);
        total_cnt++; if (s2 !== 6'd14) $display("FAIL minA_shift got=%0d exp=14", s2); else pass_cnt++;
        frame_obs(1'b0, 2, 1'b1, 32'h0001_0000, e, d1, p1, s2, u2, u3);
        total_cnt++; if (s2 !== 6'd4) $display("FAIL minB_shift got=%0d exp=4", s2); else pass_cnt++;
        total_cnt++; if (u2 !== 1'b1) $display("FAIL minB_update got=%b exp=1", u2); else pass_cnt++;
        frame_obs(1'b0, 0, 1'b0, 32'h0, e, d1, p1, s2, u2, u3);
        total_cnt++; if (d1 !== 1'b1 || p1 !== 32'h0) $display("FAIL zero_peak got=%b/%h exp=1/0", d1, p1); else pass_cnt++;
        total_cnt++; if (s2 !== 6'd4 || u2 !== 1'b0) $display("FAIL zero_shift got=%0d/%b exp=4/0", s2, u2); else pass_cnt++;
    endtask

    task automatic test_midframe_sync();
        logic seen = 1'b0;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if (frame_done) seen = 1'b1;
            din_valid  = 1'b1;
            frame_sync = (i == 0) || (i == 5);
            din1 = (i == 3) ? 32'h8000_0000 : 32'h1;
            din2 = (i == 7) ? 32'h0040_0000 : 32'h2;
        end
        @(negedge clk);
        din_valid = 1'b0; frame_sync = 1'b0;
        total_cnt++; if (seen !== 1'b0) $display("FAIL midsync_early_done got=%b exp=0", seen); else pass_cnt++;
        total_cnt++; if (frame_done !== 1'b1) $display("FAIL midsync_done got=%b exp=1", frame_done); else pass_cnt++;
        total_cnt++; if (frame_peak !== 32'h0040_0000) $display("FAIL midsync_peak got=%h exp=00400000", frame_peak); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (shift_val !== 6'd6 || shift_update !== 1'b1) $display("FAIL midsync_shift got=%0d/%b exp=6/1", shift_val, shift_update); else pass_cnt++;
    endtask

    task automatic test_reset_midway();
        logic e, d1, u2, u3, seen; logic [31:0] p1; logic [5:0] s2;
        frame_obs(1'b0, 4, 1'b0, 32'h0001_0000, e, d1, p1, s2, u2, u3);
        total_cnt++; if (s2 !== 6'd6 || u2 !== 1'b0) $display("FAIL rstA_shift got=%0d/%b exp=6/0", s2, u2); else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            din_valid = 1'b1; frame_sync = 1'b0; din1 = (i == 1) ? 32'h0001_0000 : 32'h3; din2 = 32'h5;
        end
        @(negedge clk);
        din_valid = 1'b0;
        total_cnt++; if (frame_done !== 1'b1) $display("FAIL rst_pre_done got=%b exp=1", frame_done); else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (shift_val !== 6'd14 || frame_peak !== 32'h0 || frame_done !== 1'b0 || shift_update !== 1'b0)
            $display("FAIL rst_async got=%0d/%h/%b/%b exp=14/0/0/0", shift_val, frame_peak, frame_done, shift_update); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (shift_update || frame_done || shift_val != 6'd14) seen = 1'b1;
        end
        total_cnt++; if (seen !== 1'b0) $display("FAIL rst_pending_lost got=%b exp=0", seen); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 8) begin
                total_cnt++; if (frame_done !== 1'b1 || frame_peak !== 32'h0040_0000)
                    $display("FAIL b2b1_done got=%b/%h exp=1/00400000", frame_done, frame_peak); else pass_cnt++;
            end
            if (i == 9) begin
                total_cnt++; if (shift_val !== 6'd14 || shift_update !== 1'b0 || frame_done !== 1'b0)
                    $display("FAIL b2b1_shift got=%0d/%b/%b exp=14/0/0", shift_val, shift_update, frame_done); else pass_cnt++;
            end
            din_valid  = 1'b1;
            frame_sync = (i == 0) || (i == 7);
            din1 = 32'h10;
            din2 = (i == 2 || i == 10) ? 32'h0040_0000 : 32'h1;
        end
        @(negedge clk);
        din_valid = 1'b0; frame_sync = 1'b0;
        total_cnt++; if (frame_done !== 1'b1 || frame_peak !== 32'h0040_0000)
            $display("FAIL b2b2_done got=%b/%h exp=1/00400000", frame_done, frame_peak); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (shift_val !== 6'd6 || shift_update !== 1'b1)
            $display("FAIL b2b2_shift got=%0d/%b exp=6/1", shift_val, shift_update); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_no_sync();
        test_hold_decrease();
        test_increase_clamp();
        test_min_clamp();
        test_midframe_sync();
        test_reset_midway();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
